// File: rtl/merge_pass.sv
// One bottom-up merge pass: pairwise merges sorted runs of run_len tuples from the
// source bank into runs of 2*run_len in the destination bank, one write per cycle.
module merge_pass #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  stream_len,
  input  logic [LEN_W-1:0]  run_len,
  output logic              busy,
  output logic              done,
  output logic              last_pass,
  output logic [ADDR_W-1:0] src_a_addr,
  output logic              src_a_rd_en,
  input  logic [DATA_W-1:0] src_a_data,
  output logic [ADDR_W-1:0] src_b_addr,
  output logic              src_b_rd_en,
  input  logic [DATA_W-1:0] src_b_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_wr_en
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_FILL   = 3'd2;
  localparam logic [2:0] S_MERGE  = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, run_q, run_d, base_q, base_d;
  logic [LEN_W-1:0]  a_ptr_q, a_ptr_d, a_end_q, a_end_d;
  logic [LEN_W-1:0]  b_ptr_q, b_ptr_d, b_end_q, b_end_d;
  logic [LEN_W-1:0]  w_ptr_q, w_ptr_d;
  logic [DATA_W-1:0] head_a_q, head_a_d, head_b_q, head_b_d;
  logic              a_pend_q, a_pend_d, a_hold_q, a_hold_d;
  logic              b_pend_q, b_pend_d, b_hold_q, b_hold_d;
  logic              done_q, done_d, last_q, last_d;

  logic              a_rd, b_rd, wr;
  logic [DATA_W-1:0] wdata;

  // One extra bit so base+2*run_len cannot wrap before clipping to stream_len.
  logic [LEN_W:0]    sum1, sum2, len_w, run2;
  logic              final_grp;
  logic              a_has, b_has, take_a, a_left, b_left;
  logic [DATA_W-1:0] ha, hb;

  assign len_w     = {1'b0, len_q};
  assign sum1      = {1'b0, base_q} + {1'b0, run_q};
  assign sum2      = {1'b0, base_q} + {run_q, 1'b0};
  assign run2      = {run_q, 1'b0};
  assign final_grp = (sum2 >= len_w);

  // Read data bypasses straight into the compare on the cycle it returns.
  assign a_has  = a_pend_q | a_hold_q;
  assign b_has  = b_pend_q | b_hold_q;
  assign ha     = a_pend_q ? src_a_data : head_a_q;
  assign hb     = b_pend_q ? src_b_data : head_b_q;
  assign take_a = a_has && (!b_has || (ha <= hb));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    run_d    = run_q;
    base_d   = base_q;
    a_ptr_d  = a_ptr_q;
    a_end_d  = a_end_q;
    b_ptr_d  = b_ptr_q;
    b_end_d  = b_end_q;
    w_ptr_d  = w_ptr_q;
    head_a_d = head_a_q;
    head_b_d = head_b_q;
    a_pend_d = a_pend_q;
    a_hold_d = a_hold_q;
    b_pend_d = b_pend_q;
    b_hold_d = b_hold_q;
    done_d   = 1'b0;
    last_d   = last_q;
    a_rd     = 1'b0;
    b_rd     = 1'b0;
    wr       = 1'b0;
    wdata    = '0;
    a_left   = 1'b0;
    b_left   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          len_d   = stream_len;
          run_d   = run_len;
          base_d  = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        a_ptr_d  = base_q;
        a_end_d  = (sum1 >= len_w) ? len_q : sum1[LEN_W-1:0];
        b_ptr_d  = a_end_d;
        b_end_d  = final_grp ? len_q : sum2[LEN_W-1:0];
        w_ptr_d  = base_q;
        a_pend_d = 1'b0;
        a_hold_d = 1'b0;
        b_pend_d = 1'b0;
        b_hold_d = 1'b0;
        state_d  = (base_q >= len_q) ? S_FINISH : S_FILL;
      end
      S_FILL: begin
        if (a_ptr_q < a_end_q) begin
          a_rd     = 1'b1;
          a_ptr_d  = a_ptr_q + LEN_W'(1);
          a_pend_d = 1'b1;
        end
        if (b_ptr_q < b_end_q) begin
          b_rd     = 1'b1;
          b_ptr_d  = b_ptr_q + LEN_W'(1);
          b_pend_d = 1'b1;
        end
        state_d = S_MERGE;
      end
      S_MERGE: begin
        wr      = 1'b1;
        wdata   = take_a ? ha : hb;
        w_ptr_d = w_ptr_q + LEN_W'(1);
        if (take_a) begin
          a_hold_d = 1'b0;
          a_pend_d = (a_ptr_q < a_end_q);
          a_rd     = a_pend_d;
          if (a_rd) a_ptr_d = a_ptr_q + LEN_W'(1);
          a_left   = a_rd;
        end else begin
          if (a_pend_q) begin
            head_a_d = src_a_data;
            a_hold_d = 1'b1;
            a_pend_d = 1'b0;
          end
          a_left = a_has;
        end
        if (!take_a) begin
          b_hold_d = 1'b0;
          b_pend_d = (b_ptr_q < b_end_q);
          b_rd     = b_pend_d;
          if (b_rd) b_ptr_d = b_ptr_q + LEN_W'(1);
          b_left   = b_rd;
        end else begin
          if (b_pend_q) begin
            head_b_d = src_b_data;
            b_hold_d = 1'b1;
            b_pend_d = 1'b0;
          end
          b_left = b_has;
        end
        // The last group finishes straight from its final write, so done
        // follows that write by one cycle.
        if (!a_left && !b_left) begin
          if (final_grp) begin
            done_d  = 1'b1;
            last_d  = (run2 >= len_w);
            state_d = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        base_d  = sum2[LEN_W-1:0];
        state_d = S_SETUP;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        last_d  = (run2 >= len_w);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      run_q    <= '0;
      base_q   <= '0;
      a_ptr_q  <= '0;
      a_end_q  <= '0;
      b_ptr_q  <= '0;
      b_end_q  <= '0;
      w_ptr_q  <= '0;
      head_a_q <= '0;
      head_b_q <= '0;
      a_pend_q <= 1'b0;
      a_hold_q <= 1'b0;
      b_pend_q <= 1'b0;
      b_hold_q <= 1'b0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      run_q    <= run_d;
      base_q   <= base_d;
      a_ptr_q  <= a_ptr_d;
      a_end_q  <= a_end_d;
      b_ptr_q  <= b_ptr_d;
      b_end_q  <= b_end_d;
      w_ptr_q  <= w_ptr_d;
      head_a_q <= head_a_d;
      head_b_q <= head_b_d;
      a_pend_q <= a_pend_d;
      a_hold_q <= a_hold_d;
      b_pend_q <= b_pend_d;
      b_hold_q <= b_hold_d;
      done_q   <= done_d;
      last_q   <= last_d;
    end
  end

  // Strobes are masked while reset is low so an aborted pass lands nothing more.
  assign src_a_rd_en = a_rd & reset;
  assign src_b_rd_en = b_rd & reset;
  assign dst_wr_en   = wr & reset;
  assign src_a_addr  = src_a_rd_en ? a_ptr_q[ADDR_W-1:0] : '0;
  assign src_b_addr  = src_b_rd_en ? b_ptr_q[ADDR_W-1:0] : '0;
  assign dst_addr    = dst_wr_en ? w_ptr_q[ADDR_W-1:0] : '0;
  assign dst_data    = dst_wr_en ? wdata : '0;
  assign busy        = (state_q != S_IDLE) | done_q;
  assign done        = done_q;
  assign last_pass   = last_q;

endmodule

// File: tb/tb_merge_pass.sv
// Directed bench for merge_pass: source bank model, write scoreboard, immediate-assert checks.
module tb_merge_pass;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 32;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  stream_len = '0;
  logic [LEN_W-1:0]  run_len = '0;
  logic              busy, done, last_pass;
  logic [ADDR_W-1:0] src_a_addr, src_b_addr, dst_addr;
  logic              src_a_rd_en, src_b_rd_en, dst_wr_en;
  logic [DATA_W-1:0] src_a_data = '0;
  logic [DATA_W-1:0] src_b_data = '0;
  logic [DATA_W-1:0] dst_data;

  merge_pass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset), .start(start), .stream_len(stream_len), .run_len(run_len),
    .busy(busy), .done(done), .last_pass(last_pass),
    .src_a_addr(src_a_addr), .src_a_rd_en(src_a_rd_en), .src_a_data(src_a_data),
    .src_b_addr(src_b_addr), .src_b_rd_en(src_b_rd_en), .src_b_data(src_b_data),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_wr_en(dst_wr_en)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              e;
  logic [DATA_W-1:0] mem [0:63];
  logic [DATA_W-1:0] qv[$];
  int n_chk = 0, n_pass = 0, cyc = 0;
  int wr_cnt = 0, b_rd_cnt = 0, strb_cnt = 0, done_cnt = 0;
  int first_wr = -1, last_wr = -1, done_cyc = -1, cur_len = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
    n_chk++;
    assert (got === want) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(posedge clock) begin
    cyc++;
    if (src_a_rd_en) src_a_data <= mem[src_a_addr[5:0]];
    if (src_b_rd_en) src_b_data <= mem[src_b_addr[5:0]];
  end

  // Bus monitor: read bounds, write scoreboard, done bookkeeping.
  always @(negedge clock) begin
    if (src_a_rd_en) begin
      strb_cnt++;
      check("rd_a_bound", 128'(int'(src_a_addr) < cur_len), 128'(1));
    end
    if (src_b_rd_en) begin
      strb_cnt++;
      b_rd_cnt++;
      check("rd_b_bound", 128'(int'(src_b_addr) < cur_len), 128'(1));
    end
    if (dst_wr_en) begin
      strb_cnt++;
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (exp_q.size() == 0) begin
        check("extra_wr", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 128'(dst_addr), 128'(e.addr));
        check("wr_data", dst_data, e.data);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic load_src(input logic [DATA_W-1:0] v[$]);
    for (int i = 0; i < v.size(); i++) mem[i] = v[i];
  endtask

  task automatic push_exp(input logic [DATA_W-1:0] v[$]);
    exp_t x;
    for (int i = 0; i < v.size(); i++) begin
      x.addr = ADDR_W'(i);
      x.data = v[i];
      exp_q.push_back(x);
    end
  endtask

  task automatic clear_counts(input int len);
    wr_cnt = 0; b_rd_cnt = 0; strb_cnt = 0; done_cnt = 0;
    first_wr = -1; last_wr = -1; done_cyc = -1; cur_len = len;
  endtask

  // Launch a pass, optionally poke start again while busy, wait for done (bounded).
  task automatic run_pass(input int len, input int rl, input logic exp_last, input bit poke, output int lat);
    int n;
    clear_counts(len);
    @(negedge clock);
    stream_len = LEN_W'(len); run_len = LEN_W'(rl); start = 1'b1;
    @(negedge clock);
    start = 1'b0; n = 1;
    if (poke) begin
      start = 1'b1; stream_len = '0;
      @(negedge clock);
      start = 1'b0; n++;
    end
    while (!done && n < 400) begin
      @(negedge clock);
      n++;
    end
    lat = n;
    check("done_seen", 128'(done), 128'(1));
    check("last_pass", 128'(last_pass), 128'(exp_last));
    repeat (4) @(negedge clock);
    #1;
    check("wr_count", 128'(wr_cnt), 128'(len));
    check("sb_empty", 128'(exp_q.size()), 128'(0));
    check("done_count", 128'(done_cnt), 128'(1));
    check("busy_after", 128'(busy), 128'(0));
  endtask

  initial begin
    int lat, n;
    logic [DATA_W-1:0] k71, k72, k80, v;
    logic [DATA_W-1:0] srt[$];
    k71 = {64'd7, 64'd1};
    k72 = {64'd7, 64'd2};
    k80 = {64'd8, 64'd0};

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_last", 128'(last_pass), 128'(0));
    check("rst_strobes", 128'({src_a_rd_en, src_b_rd_en, dst_wr_en}), 128'(0));
    check("rst_addrs", 128'({src_a_addr, src_b_addr, dst_addr}), 128'(0));
    reset = 1'b1;

    // run_len=1: pairs swapped where needed
    qv = '{4, 3, 2, 1}; load_src(qv);
    qv = '{3, 4, 1, 2}; push_exp(qv);
    run_pass(4, 1, 1'b0, 1'b0, lat);

    // run_len=4: full two-way merge, back-to-back writes, done one cycle after last write
    qv = '{1, 5, 9, 13, 2, 6, 10, 14}; load_src(qv);
    qv = '{1, 2, 5, 6, 9, 10, 13, 14}; push_exp(qv);
    run_pass(8, 4, 1'b1, 1'b0, lat);
    check("wr_consecutive", 128'(last_wr - first_wr), 128'(7));
    check("done_after_wr", 128'(done_cyc - last_wr), 128'(1));

    // Ties resolve toward run A
    qv = '{k71, k72, k71, k80}; load_src(qv);
    qv = '{k71, k71, k72, k80}; push_exp(qv);
    run_pass(4, 2, 1'b1, 1'b0, lat);

    // Clipped right run: reads must stay below stream_len
    qv = '{1, 3, 5, 7, 2, 4, 99, 98}; load_src(qv);
    qv = '{1, 2, 3, 4, 5, 7}; push_exp(qv);
    run_pass(6, 4, 1'b1, 1'b0, lat);

    // run_len > stream_len: plain copy, right run never read
    qv = '{9, 8, 7}; load_src(qv);
    qv = '{9, 8, 7}; push_exp(qv);
    run_pass(3, 4, 1'b1, 1'b0, lat);
    check("copy_no_b_reads", 128'(b_rd_cnt), 128'(0));

    // Empty stream: no strobes, done three cycles after start
    run_pass(0, 1, 1'b1, 1'b0, lat);
    check("zero_no_strobes", 128'(strb_cnt), 128'(0));
    check("zero_done_lat", 128'(lat), 128'(3));

    // Second start while busy is ignored
    qv = '{1, 5, 2, 3}; load_src(qv);
    qv = '{1, 2, 3, 5}; push_exp(qv);
    run_pass(4, 2, 1'b1, 1'b1, lat);

    // Abort mid-merge after three writes of a 16-tuple pass
    v = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) v = '0;
      v = v + 128'($urandom_range(0, 3));
      mem[i] = v;
    end
    srt = {};
    for (int i = 0; i < 16; i++) begin
      int p;
      p = srt.size();
      for (int j = srt.size() - 1; j >= 0; j--) if (srt[j] > mem[i]) p = j;
      srt.insert(p, mem[i]);
    end
    push_exp(srt);
    clear_counts(16);
    @(negedge clock);
    stream_len = 16; run_len = 8; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (wr_cnt < 3 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("abort_reached_3", 128'(wr_cnt), 128'(3));
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("abort_strobes", 128'({src_a_rd_en, src_b_rd_en, dst_wr_en}), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_last", 128'(last_pass), 128'(0));
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    #1;
    check("abort_no_done", 128'(done_cnt), 128'(0));
    check("abort_wr_count", 128'(wr_cnt), 128'(3));
    exp_q.delete();

    // Fresh pass after abort completes all 16 writes
    push_exp(srt);
    run_pass(16, 8, 1'b1, 1'b0, lat);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/merge_pass.md
Name: merge_pass

Overview:
- Downstream neighbour of the 16-element sort phase in the AOC5 range-sorting pipeline.
- Performs one bottom-up merge pass: reads sorted runs of length run_len from the source bank, pairwise merges them, and writes sorted runs of length 2*run_len to the destination bank.
- The top level ping-pongs banks and doubles run_len between passes (16, 32, 64, ...) until last_pass is reported.

Parameters:
- DATA_W, 128, width of one tuple (range start in MSBs, range end in LSBs); ordering is unsigned compare of the full word.
- ADDR_W, 16, tuple address width of source and destination banks.
- LEN_W, 32, width of stream_len and run_len.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; launches one pass (ignored while busy)
- stream_len  in  LEN_W  number of valid tuples; sampled at start
- run_len  in  LEN_W  current sorted-run length, power of two >=1; sampled at start
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle pulse when the pass completes
- last_pass  out  1  valid with done; 1 when 2*run_len >= stream_len
- src_a_addr  out  ADDR_W  left-run read address
- src_a_rd_en  out  1  left-run read strobe
- src_a_data  in  DATA_W  left-run read data, valid exactly 1 cycle after the strobe
- src_b_addr  out  ADDR_W  right-run read address
- src_b_rd_en  out  1  right-run read strobe
- src_b_data  in  DATA_W  right-run read data, 1-cycle latency
- dst_addr  out  ADDR_W  write address
- dst_data  out  DATA_W  write data
- dst_wr_en  out  1  write strobe

Behaviour:
- Reset (reset==0 at posedge): busy, done, last_pass, all rd_en and wr_en go to 0, all addresses go to 0, FSM goes to IDLE. This applies mid-pass too; an aborted pass issues no further writes and no done.

FSM states: IDLE, SETUP, FILL, MERGE, NEXT, FINISH.
- IDLE: on start, latch stream_len and run_len, set base=0, go to SETUP.
- SETUP: compute the group bounds.
  - a_ptr=base; a_end=min(base+run_len, stream_len).
  - b_ptr=a_end; b_end=min(base+2*run_len, stream_len).
  - If base>=stream_len, go to FINISH. Otherwise go to FILL.
- FILL: issue reads for both heads (only for non-empty runs), go to MERGE.
- MERGE: one destination write per cycle, sustained with no bubbles.
  - Head registers are refilled from read data the cycle after each read.
  - Select the smaller head. On a tie, take A (the merge is stable).
  - The write address starts at base and increments by 1 per write.
  - After consuming a head, issue a read of that run's next address if the run is not yet exhausted.
  - When one run is exhausted, drain the other at one write per cycle.
  - When both are exhausted, go to NEXT.
- NEXT: base += 2*run_len, go to SETUP.
- FINISH: pulse done for 1 cycle, drive last_pass = (2*run_len >= stream_len), clear busy, go to IDLE.

Latency and throughput:
- The first write of a group occurs 2 cycles after SETUP.
- Each group costs (group size + 3) cycles.
- done is asserted 1 cycle after the last write.

Boundary conditions:
- Tail group with an empty right run (a_end==stream_len): copy the left run unchanged. No src_b reads are issued.
- Partial right run: merge over the clipped length only. Never read at or beyond stream_len.
- stream_len==0: no reads and no writes. done is asserted 3 cycles after start, with last_pass=1.
- run_len>=stream_len: a single copy group, then last_pass=1.
- Address arithmetic is done in LEN_W bits and truncated to ADDR_W when driven. Callers guarantee stream_len <= 2^ADDR_W.
- A start coinciding with done or with reset low: reset wins. Otherwise, start in the done cycle is ignored.
- The write count per pass always equals stream_len exactly.
- dst_data, dst_addr and the read addresses are don't-care when their strobes are low.

Test Plan:
- run_len=1, stream_len=4, src=[4,3,2,1] -> dst=[3,4,1,2]; 4 writes; done with last_pass=0.
- run_len=4, stream_len=8, src=[1,5,9,13, 2,6,10,14] -> dst=[1,2,5,6,9,10,13,14]; writes on 8 consecutive cycles; last_pass=1.
- Ties and stability: run_len=2, src A={7:lo=1, 7:lo=2} vs B={7:lo=1, 8} (key=7) -> A elements precede equal B elements; output order A0, B0, A1, B1 compared on the full word.
- Tail and clip: run_len=4, stream_len=6, src=[1,3,5,7, 2,4] -> dst=[1,2,3,4,5,7]; no read at address >=6; stream_len=3 with run_len=4 -> copy of 3 tuples.
- stream_len=0 -> no strobes; done 3 cycles after start with last_pass=1. A second start while busy -> ignored; exactly one done.
- Reset asserted mid-MERGE after 3 writes of a 16-tuple pass -> next cycle all strobes 0, busy=0, no done. A fresh start then completes a full 16-write pass.
